// File: rtl/conv_encoder_framed.sv
// Rate-1/2 convolutional encoder with an input FIFO and optional zero-tail frame termination.
// Tail insertion is built only when CONV_ENC_TAIL_EN is defined.
module conv_encoder_framed #(
  parameter int             K          = 3,
  parameter logic [K-1:0]   G0         = 3'b111,
  parameter logic [K-1:0]   G1         = 3'b101,
  parameter int             FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  input  logic       last_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       last_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;

  logic [K-2:0]  r_sr;
  logic          r_valid;
  logic [1:0]    r_dout;
  logic          r_last;

  logic          w_push;
  logic          w_pop;
  logic          w_enc_slot;
  logic [CW-1:0] w_count_next;
  logic [1:0]    w_head;
  logic          w_b;
  logic [K-1:0]  w_v;
  logic [1:0]    w_sym;
  logic [K-2:0]  w_sr_next;

`ifdef CONV_ENC_TAIL_EN
  localparam int TW = $clog2(K);
  typedef enum logic {ENC, TAIL} state_t;
  state_t        r_state;
  logic [TW-1:0] r_tail_cnt;
  assign w_enc_slot = (r_state == ENC);
`else
  assign w_enc_slot = 1'b1;
`endif

  assign ready_o      = ~r_full;
  assign w_push       = enable_i & ~r_full;
  assign w_pop        = ~r_empty & w_enc_slot;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head       = r_mem[r_rd];

  // Tail cycles feed zeros; the streaming reverse puts sr[0] right after b.
  assign w_b       = w_enc_slot ? w_head[1] : 1'b0;
  assign w_v       = {w_b, {<<{r_sr}}};
  assign w_sym     = {^(G0 & w_v), ^(G1 & w_v)};
  assign w_sr_next = {r_sr[K-3:0], w_b};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {d_in, last_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(FIFO_DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= '0;
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_last  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      r_state    <= ENC;
      r_tail_cnt <= '0;
`endif
    end else begin
`ifdef CONV_ENC_TAIL_EN
      case (r_state)
        ENC: begin
          r_last <= 1'b0;
          if (w_pop) begin
            r_valid <= 1'b1;
            r_dout  <= w_sym;
            r_sr    <= w_sr_next;
            if (w_head[0]) begin
              r_state    <= TAIL;
              r_tail_cnt <= TW'(K - 1);
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        TAIL: begin
          r_valid    <= 1'b1;
          r_dout     <= w_sym;
          r_sr       <= w_sr_next;
          r_tail_cnt <= r_tail_cnt - TW'(1);
          r_last     <= (r_tail_cnt == TW'(1));
          if (r_tail_cnt == TW'(1)) r_state <= ENC;
        end
        default: r_state <= ENC;
      endcase
`else
      if (w_pop) begin
        r_valid <= 1'b1;
        r_dout  <= w_sym;
        r_sr    <= w_sr_next;
        r_last  <= w_head[0];
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
`endif
    end
  end

  assign valid_o = r_valid;
  assign d_out   = r_dout;
  assign last_o  = r_last;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Bench for conv_encoder_framed: directed frames plus random traffic against a bit-history model.
// Expectations follow CONV_ENC_TAIL_EN, matching whichever build of the design is compiled.
module tb_conv_encoder_framed;

  localparam int           K     = 3;
  localparam logic [K-1:0] G0    = 3'b111;
  localparam logic [K-1:0] G1    = 3'b101;
  localparam int           DEPTH = 8;
`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       d_in = 1'b0;
  logic       last_i = 1'b0;
  logic       ready_o;
  logic       valid_o;
  logic [1:0] d_out;
  logic       last_o;

  conv_encoder_framed #(.K(K), .G0(G0), .G1(G1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .last_i(last_i),
    .ready_o(ready_o), .valid_o(valid_o), .d_out(d_out), .last_o(last_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] d;
    logic       last;
    logic       is_data;
  } sym_t;

  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_popped = 0;
  bit   seen_full = 1'b0;
  sym_t exp_q[$];
  bit   hist[$];
  bit   fbits[64];
  bit   flast[64];
  logic [1:0] cap_d[$];
  logic       cap_l[$];
  int   cap_gaps;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Parity from the bit history: delay j taps generator bit K-1-j.
  function automatic logic [1:0] enc_sym(input bit b);
    bit s0 = 1'b0;
    bit s1 = 1'b0;
    for (int j = 0; j < K; j++) begin
      bit x;
      x = (j == 0) ? b : ((j - 1 < hist.size()) ? hist[j-1] : 1'b0);
      if (G0[K-1-j]) s0 ^= x;
      if (G1[K-1-j]) s1 ^= x;
    end
    return {s0, s1};
  endfunction

  function automatic void model_bit(input bit b, input bit l, input bit is_data);
    sym_t s;
    s.d       = enc_sym(b);
    s.last    = l;
    s.is_data = is_data;
    hist.push_front(b);
    while (hist.size() > K - 1) void'(hist.pop_back());
    exp_q.push_back(s);
  endfunction

  function automatic void model_push(input bit b, input bit l);
    model_bit(b, TAIL ? 1'b0 : l, 1'b1);
    if (TAIL && l)
      for (int t = 1; t < K; t++) model_bit(1'b0, t == K - 1, 1'b0);
  endfunction

  always @(posedge clk) begin
    if (!rst && enable_i && ready_o) begin
      n_acc++;
      model_push(d_in, last_i);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        check("sym_avail", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sym_t e;
          e = exp_q.pop_front();
          check("sym_d", int'(d_out), int'(e.d));
          check("sym_last", int'(last_o), int'(e.last));
          if (e.is_data) n_popped++;
        end
      end
      if (!ready_o) begin
        seen_full = 1'b1;
        check("full_occupancy", n_acc - n_popped, DEPTH);
      end
    end
  end

  task automatic send(input int n, input bit gaps);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        enable_i = 1'b0;
      end else begin
        enable_i = 1'b1;
        d_in     = fbits[idx];
        last_i   = flast[idx];
        if (ready_o) idx++;
      end
    end
    check("send_accepted", idx, n);
    @(negedge clk);
    enable_i = 1'b0;
    last_i   = 1'b0;
  endtask

  task automatic collect(input int n);
    int got = 0;
    int waited = 0;
    cap_d.delete();
    cap_l.delete();
    cap_gaps = 0;
    while (got < n && waited < 100) begin
      @(negedge clk);
      waited++;
      if (valid_o) begin
        cap_d.push_back(d_out);
        cap_l.push_back(last_o);
        got++;
      end else if (got > 0) begin
        cap_gaps++;
      end
    end
    check("collect_count", got, n);
    while (cap_d.size() < n) begin
      cap_d.push_back(2'b00);
      cap_l.push_back(1'b0);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() > 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("ready_idle", int'(ready_o), 1);
  endtask

  task automatic reset_outputs_check();
    check("rst_valid", int'(valid_o), 0);
    check("rst_dout", int'(d_out), 0);
    check("rst_last", int'(last_o), 0);
    check("rst_ready", int'(ready_o), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst      = 1'b1;
    enable_i = 1'b0;
    last_i   = 1'b0;
    exp_q.delete();
    hist.delete();
    n_acc    = 0;
    n_popped = 0;
    #1;
    reset_outputs_check();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic basic_frame();
    logic [1:0] want_d [6];
    want_d = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
    fbits[0] = 1; fbits[1] = 0; fbits[2] = 1; fbits[3] = 1;
    flast[0] = 0; flast[1] = 0; flast[2] = 0; flast[3] = 1;
`ifdef CONV_ENC_TAIL_EN
    fork
      send(4, 1'b0);
      collect(6);
    join
    for (int i = 0; i < 6; i++) begin
      check("basic_d", int'(cap_d[i]), int'(want_d[i]));
      check("basic_last", int'(cap_l[i]), int'(i == 5));
    end
`else
    fork
      send(4, 1'b0);
      collect(4);
    join
    for (int i = 0; i < 4; i++) begin
      check("basic_d", int'(cap_d[i]), int'(want_d[i]));
      check("basic_last", int'(cap_l[i]), int'(i == 3));
    end
`endif
    check("basic_gaps", cap_gaps, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_outputs_check();
    rst = 1'b0;
    @(negedge clk);

    // Single-bit latency from idle
    enable_i = 1'b1; d_in = 1'b1; last_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b0;
    check("lat_early_valid", int'(valid_o), 0);
    @(negedge clk);
    check("lat_valid", int'(valid_o), 1);
    check("lat_dout", int'(d_out), 3);
    do_reset();

    basic_frame();
`ifndef CONV_ENC_TAIL_EN
    fbits[0] = 0; flast[0] = 1;
    fork
      send(1, 1'b0);
      collect(1);
    join
    check("carry_d", int'(cap_d[0]), 1);
    check("carry_last", int'(cap_l[0]), 1);
`endif
    drain();
    do_reset();

    // Sustained input; single-bit frames with tails overrun the pop rate
    seen_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fbits[i] = 1'($urandom_range(0, 1));
      flast[i] = TAIL ? 1'b1 : (i == 15);
    end
    send(16, 1'b0);
    drain();
`ifdef CONV_ENC_TAIL_EN
    check("ready_dropped", int'(seen_full), 1);

    // Two identical 3-bit frames back to back
    for (int i = 0; i < 6; i++) begin
      fbits[i] = (i % 3 != 2);
      flast[i] = (i % 3 == 2);
    end
    fork
      send(6, 1'b0);
      collect(10);
    join
    check("b2b_gaps", cap_gaps, 0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] want [5];
      want = '{2'd3, 2'd1, 2'd1, 2'd3, 2'd0};
      check("b2b_d", int'(cap_d[i]), int'(want[i % 5]));
      check("b2b_last", int'(cap_l[i]), int'(i % 5 == 4));
    end
    drain();

    // Reset during the first tail symbol
    @(negedge clk);
    enable_i = 1'b1; d_in = 1'b1; last_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b0; last_i = 1'b0;
    @(posedge clk);
    do_reset();
    basic_frame();
    drain();
`else
    check("ready_never_dropped", int'(seen_full), 0);
`endif

    do_reset();
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        fbits[i] = 1'($urandom_range(0, 1));
        flast[i] = (i == len - 1);
      end
      send(len, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
